descrambler_sync: RTL

DESCRAMBLER_SYNC -- requirements
Module: descrambler_sync

---
 rtl/scram_pkg.sv | 41 ++++
 rtl/descram_lfsr.sv | 36 +++
 rtl/descrambler_sync.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/scram_pkg.sv
// Definitions shared by the scrambler and descrambler ends of the link:
// sync FSM states, LFSR polynomial, default seed and the 16-bit parallel keystream.
package scram_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_e;

    // x^16 + x^5 + x^4 + x^3 + 1
    localparam logic [16:0] SCRAM_POLY         = 17'h1_0039;
    localparam logic [15:0] SCRAM_SEED_DEFAULT = 16'hFFFF;

    // Fibonacci form: s[15] is the oldest bit and leaves first; term x^k taps s[k-1].
    function automatic logic scram_feedback(input logic [15:0] s);
        return s[15] ^ (^(s[14:0] & SCRAM_POLY[15:1]));
    endfunction

    function automatic logic [15:0] scram_keystream(input logic [15:0] state);
        logic [15:0] s;
        logic [15:0] ks;
        s  = state;
        ks = '0;
        for (int i = 0; i < 16; i++) begin
            ks = {ks[14:0], s[15]};
            s  = {s[14:0], scram_feedback(s)};
        end
        return ks;
    endfunction

    function automatic logic [15:0] scram_next(input logic [15:0] state);
        logic [15:0] s;
        s = state;
        for (int i = 0; i < 16; i++) begin
            s = {s[14:0], scram_feedback(s)};
        end
        return s;
    endfunction

endpackage

// File: rtl/descram_lfsr.sv
// Keystream LFSR for the descrambler: seed load has priority over a 16-bit parallel step.
module descram_lfsr
    import scram_pkg::*;
#(
    parameter logic [15:0] SEED = SCRAM_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_load,
    input  logic        step_en,
    output logic [15:0] state
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (seed_load) begin
            state_d = SEED;
        end else if (step_en) begin
            state_d = scram_next(state_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/descrambler_sync.sv
// Frame-synchronising descrambler: hunts for TRAIN_WORD at slot 0, locks after LOCK_CNT hits.
// Define DESCRAM_ERR_CNT_EN to add the err_clr/err_cnt saturating slot-0 miss counter.
module descrambler_sync
    import scram_pkg::*;
#(
    parameter int              WIDTH      = 16,
    parameter logic [WIDTH-1:0] TRAIN_WORD = 16'h4A5F,
    parameter int              PERIOD     = 64,
    parameter int              LOCK_CNT   = 4,
    parameter int              MISS_MAX   = 3,
    parameter logic [15:0]     LFSR_SEED  = SCRAM_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             locked
`ifdef DESCRAM_ERR_CNT_EN
    ,
    input  logic             err_clr,
    output logic [7:0]       err_cnt
`endif
);

    localparam int SLOT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(MISS_MAX + 1);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PERIOD - 1);

    sync_state_e       state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d, slot_next;
    logic [HIT_W-1:0]  hit_q, hit_d, hit_inc;
    logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic              locked_q, locked_d;
    logic              seed_load, lfsr_step;
    logic [15:0]       lfsr_state, keystream;
    logic              is_train, at_train_slot;

    descram_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .seed_load (seed_load),
        .step_en   (lfsr_step),
        .state     (lfsr_state)
    );

    assign keystream     = scram_keystream(lfsr_state);
    assign is_train      = (in_data == TRAIN_WORD);
    assign at_train_slot = (slot_q == '0);
    assign slot_next     = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
    assign hit_inc       = hit_q + 1'b1;
    assign miss_inc      = miss_q + 1'b1;

    // Slot-0 words are never forwarded and never step the LFSR; only data slots do.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        hit_d       = hit_q;
        miss_d      = miss_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        seed_load   = 1'b0;
        lfsr_step   = 1'b0;
        if (in_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (is_train) begin
                        seed_load = 1'b1;
                        slot_d    = SLOT_W'(1);
                        hit_d     = HIT_W'(1);
                        state_d   = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    slot_d = slot_next;
                    if (at_train_slot) begin
                        if (is_train) begin
                            seed_load = 1'b1;
                            hit_d     = hit_inc;
                            if (hit_inc == HIT_W'(LOCK_CNT)) begin
                                state_d = ST_LOCKED;
                                miss_d  = '0;
                            end
                        end else begin
                            state_d = ST_SEARCH;
                            hit_d   = '0;
                        end
                    end else begin
                        lfsr_step = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    slot_d = slot_next;
                    if (at_train_slot) begin
                        if (is_train) begin
                            seed_load = 1'b1;
                            miss_d    = '0;
                        end else if (miss_inc == MISS_W'(MISS_MAX)) begin
                            state_d = ST_SEARCH;
                            miss_d  = '0;
                            hit_d   = '0;
                        end else begin
                            miss_d = miss_inc;
                        end
                    end else begin
                        lfsr_step   = 1'b1;
                        out_valid_d = 1'b1;
                        out_data_d  = in_data ^ WIDTH'(keystream);
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            slot_q      <= '0;
            hit_q       <= '0;
            miss_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            locked_q    <= locked_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign locked    = locked_q;

`ifdef DESCRAM_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_incr;

    // A clear in the same cycle as a miss wins.
    always_comb begin
        err_incr  = in_valid && (state_q == ST_LOCKED) && at_train_slot && !is_train;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_incr && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
